// File: rtl/counter_rollover_cascade_pkg.sv
// Shared helpers for the segmented rollover counter.
// Segment width derivation and parameter legality check.
package counter_rollover_cascade_pkg;

    function automatic int seg_width(input int w, input int n);
        return w / n;
    endfunction

    function automatic bit params_ok(input int w, input int n);
        return (n >= 1) && (w >= n) && ((w % n) == 0);
    endfunction

endpackage

// File: rtl/counter_rollover_cascade_if.sv
// Control and data bundle of the rollover counter.
// The master drives enable/load/data; the counter drives DO.
interface counter_rollover_cascade_if #(
    parameter int W = 8
);
    logic         ENABLE;
    logic         LOAD;
    logic [W-1:0] DI;
    logic [W-1:0] DO;

    modport master (output ENABLE, output LOAD, output DI, input DO);
    modport slave  (input ENABLE, input LOAD, input DI, output DO);
endinterface

// File: rtl/counter_rollover_cascade_segment.sv
// One S-bit slice of the cascaded counter.
// Increments when its carry-in is set; load overrides counting.
module counter_rollover_segment #(
    parameter int S = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         LOAD,
    input  logic [S-1:0] DI,
    input  logic         CI,
    output logic [S-1:0] Q,
    output logic         CO
);
    logic [S-1:0] q_q;
    logic [S-1:0] q_d;

    // Next value: load wins, then carry-driven increment, else hold
    always_comb begin
        q_d = q_q;
        if (LOAD) begin
            q_d = DI;
        end else if (CI) begin
            q_d = q_q + S'(1);
        end
    end

    // Slice register, cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign CO = CI & (&q_q);
endmodule

// File: rtl/counter_rollover_cascade.sv
// W-bit rollover counter built from N chained segments.
// Carry ripples combinationally; wrap at all-ones is silent.
module counter_rollover_cascade
    import counter_rollover_cascade_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 2
) (
    input logic                      CLK,
    input logic                      RST_N,
    counter_rollover_cascade_if.slave bus
);
    localparam int S = seg_width(W, N);

    if (!params_ok(W, N)) begin : g_bad_params
        $fatal(1, "counter_rollover_cascade: W must be a multiple of N, N >= 1");
    end

    logic [N:0]   carry;
    logic [W-1:0] cnt;
    logic         carry_unused;

    assign carry[0]     = bus.ENABLE;
    assign carry_unused = carry[N];

    for (genvar k = 0; k < N; k++) begin : g_seg
        counter_rollover_segment #(
            .S (S)
        ) u_seg (
            .CLK   (CLK),
            .RST_N (RST_N),
            .LOAD  (bus.LOAD),
            .DI    (bus.DI[k*S +: S]),
            .CI    (carry[k]),
            .Q     (cnt[k*S +: S]),
            .CO    (carry[k+1])
        );
    end

    assign bus.DO = cnt;
endmodule

// File: tb/tb_counter_rollover_cascade.sv
// Bench for counter_rollover_cascade (8/2 and 16/4 builds).
// Reference model feeds a queue; outputs popped after each edge.
module tb_counter_rollover_cascade;
    logic CLK = 1'b0;
    logic RST_N;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  ref8;
    logic [15:0] ref16;
    logic [7:0]  sb8[$];
    logic [15:0] sb16[$];

    counter_rollover_cascade_if #(.W(8))  b8 ();
    counter_rollover_cascade_if #(.W(16)) b16 ();

    counter_rollover_cascade #(.W(8), .N(2)) dut8 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b8.slave)
    );

    counter_rollover_cascade #(.W(16), .N(4)) dut16 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (b16.slave)
    );

    always #5 CLK = ~CLK;

    task automatic drive8(input logic en, input logic ld, input logic [7:0] di);
        b8.ENABLE = en;
        b8.LOAD   = ld;
        b8.DI     = di;
        if (ld) ref8 = di;
        else if (en) ref8 = ref8 + 8'd1;
        sb8.push_back(ref8);
        @(posedge CLK);
        #1;
    endtask

    task automatic drive16(input logic en, input logic ld, input logic [15:0] di);
        b16.ENABLE = en;
        b16.LOAD   = ld;
        b16.DI     = di;
        if (ld) ref16 = di;
        else if (en) ref16 = ref16 + 16'd1;
        sb16.push_back(ref16);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] exp;
        RST_N = 1'b1;
        b8.ENABLE = 1'b1; b8.LOAD = 1'b0; b8.DI = 8'h00;
        b16.ENABLE = 1'b0; b16.LOAD = 1'b0; b16.DI = 16'h0000;
        #3;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (b8.DO !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: DO=%h expected 00", b8.DO);
        end
        n_checks++;
        if (b16.DO !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async16: DO=%h expected 0000", b16.DO);
        end
        for (int i = 0; i < 3; i++) begin
            b8.LOAD = 1'($urandom_range(0, 1));
            b8.DI   = 8'($urandom);
            @(posedge CLK);
            #1;
            n_checks++;
            if (b8.DO !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: DO=%h expected 00", i, b8.DO);
            end
        end
        RST_N = 1'b1;
        ref8  = 8'h00;
        ref16 = 16'h0000;
        drive8(1'b1, 1'b0, 8'h00);
        exp = sb8.pop_front();
        n_checks++;
        if (b8.DO !== exp) begin
            n_fail++;
            $display("FAIL reset_release: DO=%h expected %h", b8.DO, exp);
        end
    endtask

    task automatic test_load_count;
        logic [7:0] exp;
        drive8(1'b0, 1'b1, 8'h00);
        exp = sb8.pop_front();
        n_checks++;
        if (b8.DO !== exp) begin
            n_fail++;
            $display("FAIL load_zero: DO=%h expected %h", b8.DO, exp);
        end
        for (int i = 1; i <= 20; i++) begin
            drive8(1'b1, 1'b0, 8'h00);
            exp = sb8.pop_front();
            n_checks++;
            if (b8.DO !== exp || exp !== 8'(i)) begin
                n_fail++;
                $display("FAIL count[%0d]: DO=%h expected %h", i, b8.DO, 8'(i));
            end
        end
    endtask

    task automatic test_segment_carry;
        logic [7:0] exp;
        logic [7:0] seeds [2];
        seeds[0] = 8'h0F;
        seeds[1] = 8'hEF;
        foreach (seeds[i]) begin
            drive8(1'b0, 1'b1, seeds[i]);
            void'(sb8.pop_front());
            drive8(1'b1, 1'b0, 8'h00);
            exp = sb8.pop_front();
            n_checks++;
            if (b8.DO !== exp) begin
                n_fail++;
                $display("FAIL seg_carry[%h]: DO=%h expected %h", seeds[i], b8.DO, exp);
            end
        end
    endtask

    task automatic test_rollover;
        logic [7:0] exp;
        drive8(1'b1, 1'b1, 8'hFE);
        for (int i = 0; i < 3; i++) drive8(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            exp = sb8.pop_front();
            n_checks++;
            if (exp !== 8'hFE + 8'(i)) begin
                n_fail++;
                $display("FAIL roll_model[%0d]: model=%h", i, exp);
            end
        end
        n_checks++;
        if (b8.DO !== 8'h01) begin
            n_fail++;
            $display("FAIL rollover8: DO=%h expected 01", b8.DO);
        end
    endtask

    task automatic test_rollover_w16;
        logic [15:0] exp;
        logic [15:0] seeds [3];
        seeds[0] = 16'h0FFF;
        seeds[1] = 16'h00FF;
        seeds[2] = 16'hFFFE;
        foreach (seeds[i]) begin
            drive16(1'b0, 1'b1, seeds[i]);
            exp = sb16.pop_front();
            n_checks++;
            if (b16.DO !== exp) begin
                n_fail++;
                $display("FAIL load16[%0d]: DO=%h expected %h", i, b16.DO, exp);
            end
            for (int j = 0; j < 3; j++) begin
                drive16(1'b1, 1'b0, 16'h0000);
                exp = sb16.pop_front();
                n_checks++;
                if (b16.DO !== exp) begin
                    n_fail++;
                    $display("FAIL step16[%0d.%0d]: DO=%h expected %h", i, j, b16.DO, exp);
                end
            end
        end
        n_checks++;
        if (b16.DO !== 16'h0001) begin
            n_fail++;
            $display("FAIL rollover16: DO=%h expected 0001", b16.DO);
        end
    endtask

    task automatic test_hold;
        logic [7:0] exp;
        drive8(1'b0, 1'b1, 8'hA3);
        void'(sb8.pop_front());
        for (int i = 0; i < 5; i++) begin
            b8.DI = 8'($urandom);
            drive8(1'b0, 1'b0, b8.DI);
            exp = sb8.pop_front();
            n_checks++;
            if (b8.DO !== exp || exp !== 8'hA3) begin
                n_fail++;
                $display("FAIL hold[%0d]: DO=%h expected A3", i, b8.DO);
            end
        end
    endtask

    task automatic test_priority;
        logic [7:0] exp;
        drive8(1'b1, 1'b1, 8'h5A);
        exp = sb8.pop_front();
        n_checks++;
        if (b8.DO !== exp || exp !== 8'h5A) begin
            n_fail++;
            $display("FAIL load_over_en: DO=%h expected 5A", b8.DO);
        end
        drive8(1'b1, 1'b0, 8'h00);
        exp = sb8.pop_front();
        n_checks++;
        if (b8.DO !== exp) begin
            n_fail++;
            $display("FAIL after_load: DO=%h expected %h", b8.DO, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp;
        drive8(1'b1, 1'b1, 8'h37);
        exp = sb8.pop_front();
        n_checks++;
        if (b8.DO !== exp) begin
            n_fail++;
            $display("FAIL mid_load: DO=%h expected %h", b8.DO, exp);
        end
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (b8.DO !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: DO=%h expected 00", b8.DO);
        end
        b8.LOAD = 1'b1;
        b8.DI   = 8'hC4;
        @(posedge CLK);
        #1;
        n_checks++;
        if (b8.DO !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_over_load: DO=%h expected 00", b8.DO);
        end
        RST_N = 1'b1;
        ref8  = 8'h00;
        ref16 = 16'h0000;
        drive8(1'b1, 1'b0, 8'h00);
        exp = sb8.pop_front();
        n_checks++;
        if (b8.DO !== exp) begin
            n_fail++;
            $display("FAIL post_reset: DO=%h expected %h", b8.DO, exp);
        end
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_segment_carry();
        test_rollover();
        test_rollover_w16();
        test_hold();
        test_priority();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
